// File: rtl/picorv32_memsim.sv
// picorv32_memsim: behavioural memory and MMIO model for the PicoRV32 native bus.
// Configurable read/write latency, optional LFSR stalls, console/exit/cycle registers.
module picorv32_memsim #(
    parameter int          MEM_BYTES    = 262144,
    parameter int          READ_LAT     = 1,
    parameter int          WRITE_LAT    = 1,
    parameter bit          RAND_STALL   = 1'b0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'h2000_0000,
    parameter logic [31:0] CYCLE_ADDR   = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        console_valid,
    output logic [7:0]  console_char,
    output logic        exit_valid,
    output logic [31:0] exit_code
);

    localparam int         AW   = $clog2(MEM_BYTES / 4);
    localparam logic [4:0] RLAT = 5'(READ_LAT);
    localparam logic [4:0] WLAT = 5'(WRITE_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] lfsr_q;
    logic [31:0] cycle_q;
    logic [31:0] rdata_q;
    logic        cons_v_q;
    logic [7:0]  cons_c_q;
    logic        exit_v_q;
    logic [31:0] exit_c_q;

    logic [31:0] mem [MEM_BYTES/4];

    logic          accept, commit, wr;
    logic          is_con, is_exit, is_cyc, is_mmio;
    logic [1:0]    extra;
    logic [4:0]    lat;
    logic          fb;
    logic [AW-1:0] idx;
    logic          unused_instr;

    assign unused_instr = mem_instr;

    assign accept  = (state_q == IDLE) && mem_valid;
    assign extra   = RAND_STALL ? lfsr_q[1:0] : 2'd0;
    assign lat     = ((|mem_wstrb) ? WLAT : RLAT) + {3'd0, extra};
    assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign wr      = |wstrb_q;
    assign idx     = addr_q[AW+1:2];
    // MMIO decode uses the full address, before the memory wrap
    assign is_con  = (addr_q == CONSOLE_ADDR);
    assign is_exit = (addr_q == EXIT_ADDR);
    assign is_cyc  = (addr_q == CYCLE_ADDR);
    assign is_mmio = is_con | is_exit | is_cyc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    state_d = WAIT;
                    cnt_d   = lat - 5'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            lfsr_q   <= LFSR_SEED;
            cycle_q  <= 32'd0;
            rdata_q  <= 32'd0;
            cons_v_q <= 1'b0;
            cons_c_q <= 8'd0;
            exit_v_q <= 1'b0;
            exit_c_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycle_q  <= cycle_q + 32'd1;
            rdata_q  <= 32'd0;
            cons_v_q <= 1'b0;
            if (RAND_STALL) lfsr_q <= {lfsr_q[14:0], fb};
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (commit) begin
                if (!wr) begin
                    rdata_q <= is_cyc ? cycle_q : (is_mmio ? 32'd0 : mem[idx]);
                end else if (is_con && wstrb_q[0]) begin
                    cons_v_q <= 1'b1;
                    cons_c_q <= wdata_q[7:0];
                end else if (is_exit && !exit_v_q) begin
                    exit_v_q <= 1'b1;
                    exit_c_q <= wdata_q;
                end
            end
        end
    end

    // Memory is never reset so its contents survive an aborted transaction
    always_ff @(posedge clk) begin
        if (resetn && commit && wr && !is_mmio) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        mem_ready     = (state_q == RESP);
        mem_rdata     = rdata_q;
        console_valid = cons_v_q;
        console_char  = cons_c_q;
        exit_valid    = exit_v_q;
        exit_code     = exit_c_q;
    end

endmodule

// File: tb/tb_picorv32_memsim.sv
// tb_picorv32_memsim: directed vector bench for picorv32_memsim.
// Three instances cover fast, slow and randomly stalled configurations.
module tb_picorv32_memsim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstn, valid, ready, cv, ev;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [31:0] ec [3];
    logic [3:0]  wstrb [3];
    logic [7:0]  cc [3];

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] CON = 32'h1000_0000;
    localparam logic [31:0] EXT = 32'h2000_0000;
    localparam logic [31:0] CYC = 32'h3000_0000;

    picorv32_memsim #(.MEM_BYTES(1024), .READ_LAT(1), .WRITE_LAT(1)) u0 (
        .clk(clk), .resetn(rstn[0]), .mem_valid(valid[0]), .mem_instr(1'b0),
        .mem_ready(ready[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]), .console_valid(cv[0]),
        .console_char(cc[0]), .exit_valid(ev[0]), .exit_code(ec[0]));

    picorv32_memsim #(.MEM_BYTES(1024), .READ_LAT(4), .WRITE_LAT(4)) u1 (
        .clk(clk), .resetn(rstn[1]), .mem_valid(valid[1]), .mem_instr(1'b1),
        .mem_ready(ready[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]), .console_valid(cv[1]),
        .console_char(cc[1]), .exit_valid(ev[1]), .exit_code(ec[1]));

    picorv32_memsim #(.MEM_BYTES(1024), .READ_LAT(2), .WRITE_LAT(1),
                      .RAND_STALL(1'b1)) u2 (
        .clk(clk), .resetn(rstn[2]), .mem_valid(valid[2]), .mem_instr(1'b0),
        .mem_ready(ready[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_wstrb(wstrb[2]), .mem_rdata(rdata[2]), .console_valid(cv[2]),
        .console_char(cc[2]), .exit_valid(ev[2]), .exit_code(ec[2]));

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] er;
        int          el;
        logic        ecv;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 with the instance idle; returns edges to ready
    task automatic xact(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output int lat, output logic c);
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = s;
        valid[k] = 1'b1;
        @(posedge clk); #1;
        valid[k] = 1'b0;
        addr[k]  = ~a;
        wdata[k] = ~d;
        wstrb[k] = ~s;
        lat = 0;
        rd  = 32'd0;
        c   = 1'b0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ready[k]) begin
                rd = rdata[k];
                c  = cv[k];
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, c1, c2;
        int          lat, bad, mn, mx;
        logic        c, seen;

        tv[0]  = '{32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 1, 1'b0};
        tv[1]  = '{32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1'b0};
        tv[2]  = '{32'h103, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1'b0};
        tv[3]  = '{32'h104, 32'hA5A5A5A5, 4'hF, 32'h0, 1, 1'b0};
        tv[4]  = '{32'h104, 32'h00FF0000, 4'h4, 32'h0, 1, 1'b0};
        tv[5]  = '{32'h104, 32'h0, 4'h0, 32'hA5FFA5A5, 1, 1'b0};
        tv[6]  = '{32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1, 1'b0};
        tv[7]  = '{32'h000, 32'h0, 4'h0, 32'hCAFEF00D, 1, 1'b0};
        tv[8]  = '{32'h500, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1'b0};
        tv[9]  = '{CON, 32'h00000041, 4'hF, 32'h0, 1, 1'b1};
        tv[10] = '{32'h000, 32'h0, 4'h0, 32'hCAFEF00D, 1, 1'b0};
        tv[11] = '{CON, 32'h000042FF, 4'h2, 32'h0, 1, 1'b0};
        tv[12] = '{CON, 32'h0, 4'h0, 32'h0, 1, 1'b0};
        tv[13] = '{EXT, 32'h0, 4'h0, 32'h0, 1, 1'b0};
        tv[14] = '{EXT, 32'h7, 4'hF, 32'h0, 1, 1'b0};
        tv[15] = '{EXT, 32'h9, 4'hF, 32'h0, 1, 1'b0};
        tv[16] = '{32'h000, 32'h0, 4'h0, 32'hCAFEF00D, 1, 1'b0};

        rstn  = 3'b000;
        valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr[k]  = 32'd0;
            wdata[k] = 32'd0;
            wstrb[k] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
            chk($sformatf("rst_cv%0d", k), 32'(cv[k]), 32'd0);
            chk($sformatf("rst_cc%0d", k), 32'(cc[k]), 32'd0);
            chk($sformatf("rst_ev%0d", k), 32'(ev[k]), 32'd0);
            chk($sformatf("rst_ec%0d", k), ec[k], 32'd0);
        end
        rstn = 3'b111;

        for (int i = 0; i < 17; i++) begin
            xact(0, tv[i].a, tv[i].d, tv[i].s, rd, lat, c);
            chk($sformatf("v%0d_rdata", i), rd, tv[i].er);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].el));
            chk($sformatf("v%0d_cons", i), 32'(c), 32'(tv[i].ecv));
        end
        chk("console_char", 32'(cc[0]), 32'h41);
        chk("exit_valid", 32'(ev[0]), 32'd1);
        chk("exit_code", ec[0], 32'd7);
        chk("idle_cv", 32'(cv[0]), 32'd0);
        chk("idle_ready", 32'(ready[0]), 32'd0);
        chk("idle_rdata", rdata[0], 32'd0);

        xact(0, CYC, 32'h0, 4'h0, c1, lat, c);
        xact(0, CYC, 32'h0, 4'h0, c2, lat, c);
        chk("cycle_delta", c2 - c1, 32'd3);

        xact(1, 32'h200, 32'hAABBCCDD, 4'hF, rd, lat, c);
        chk("u1_wlat0", 32'(lat), 32'd4);
        xact(1, 32'h200, 32'h11223344, 4'b0101, rd, lat, c);
        chk("u1_wlat1", 32'(lat), 32'd4);
        chk("u1_wrdata", rd, 32'd0);
        xact(1, 32'h200, 32'h0, 4'h0, rd, lat, c);
        chk("u1_rlat", 32'(lat), 32'd4);
        chk("u1_merge", rd, 32'hAA22CC44);
        xact(1, 32'h300, 32'h12345678, 4'hF, rd, lat, c);

        addr[1]  = 32'h300;
        wdata[1] = 32'hFFFFFFFF;
        wstrb[1] = 4'hF;
        valid[1] = 1'b1;
        @(posedge clk); #1;
        valid[1] = 1'b0;
        chk("wait_ready", 32'(ready[1]), 32'd0);
        chk("wait_rdata", rdata[1], 32'd0);
        @(posedge clk); #1;
        rstn[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= ready[1];
        end
        chk("abort_ready", 32'(seen), 32'd0);
        xact(1, 32'h300, 32'h0, 4'h0, rd, lat, c);
        chk("abort_mem", rd, 32'h12345678);

        bad = 0;
        mn  = 99;
        mx  = 0;
        for (int i = 0; i < 1000; i++) begin
            xact(2, 32'(i * 4), 32'h0, 4'h0, rd, lat, c);
            if (lat < 2 || lat > 5) bad++;
            if (lat < mn) mn = lat;
            if (lat > mx) mx = lat;
        end
        chk("stall_range", 32'(bad), 32'd0);
        chk("stall_min", 32'(mn), 32'd2);
        chk("stall_max", 32'(mx), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
